// File: rtl/duration_pkg.sv
// Shared types and constants for the duration detector: event durations,
// the rest index and the eighth-note length helper.
package duration_pkg;

   typedef enum logic [2:0] {
      DUR_NONE,
      DUR_EIGHTH,
      DUR_QUARTER,
      DUR_HALF,
      DUR_WHOLE
   } duration_t;

   localparam logic [5:0] REST_INDEX = 6'd0;

   // Eighth-note length in samples: half a beat at the given tempo.
   function automatic int unsigned eighth_len(input int unsigned bpm,
                                              input int unsigned sample_hz);
      return (sample_hz * 30) / bpm;
   endfunction

endpackage

// File: rtl/duration_quantizer.sv
// Maps a completed run length to a note duration class.
// DURATION_DETECTOR_GLITCH_FILTER_EN drops runs shorter than half an eighth.
module duration_quantizer
   import duration_pkg::*;
#(
   parameter int unsigned E  = 1500,
   parameter int unsigned CW = 14
) (
   input  logic [CW-1:0] run_len_i,
   output duration_t     dur_o
);

   localparam logic [CW-1:0] T_GLITCH  = CW'(E / 2);
   localparam logic [CW-1:0] T_QUARTER = CW'((3 * E) / 2);
   localparam logic [CW-1:0] T_HALF    = CW'(3 * E);
   localparam logic [CW-1:0] T_WHOLE   = CW'(6 * E);

   always_comb begin
      dur_o = DUR_WHOLE;
      if (run_len_i == '0) begin
         dur_o = DUR_NONE;
      end else if (run_len_i < T_GLITCH) begin
`ifdef DURATION_DETECTOR_GLITCH_FILTER_EN
         dur_o = DUR_NONE;
`else
         dur_o = DUR_EIGHTH;
`endif
      end else if (run_len_i < T_QUARTER) begin
         dur_o = DUR_EIGHTH;
      end else if (run_len_i < T_HALF) begin
         dur_o = DUR_QUARTER;
      end else if (run_len_i < T_WHOLE) begin
         dur_o = DUR_HALF;
      end
   end

endmodule

// File: rtl/duration_detector.sv
// Turns a strobed pitch-index stream into note/rest events with quantized duration.
// Optional glitch filtering via DURATION_DETECTOR_GLITCH_FILTER_EN (see quantizer).
module duration_detector
   import duration_pkg::*;
#(
   parameter int unsigned BPM       = 120,
   parameter int unsigned SAMPLE_HZ = 6000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [5:0] note_index,
   input  logic       note_index_ready,
   output logic       new_note_ready,
   output logic [5:0] new_note_tone,
   output logic       eighth_note,
   output logic       quarter_note,
   output logic       half_note,
   output logic       whole_note,
   output logic       eighth_rest,
   output logic       quarter_rest,
   output logic       half_rest,
   output logic       whole_rest
);

   localparam int unsigned E         = eighth_len(BPM, SAMPLE_HZ);
   localparam int unsigned WHOLE_LEN = 8 * E;
   localparam int unsigned CW        = $clog2(WHOLE_LEN + 1);
   localparam logic [CW-1:0] WHOLE_CNT = CW'(WHOLE_LEN);

   logic [5:0]    cur_tone_q, cur_tone_d;
   logic [CW-1:0] run_len_q, run_len_d;
   logic          ready_q;
   logic [5:0]    tone_q;
   logic [3:0]    note_flags_q, rest_flags_q;
   duration_t     quant_dur, emit_dur;

   function automatic logic [3:0] dur_onehot(input duration_t d);
      case (d)
         DUR_EIGHTH:  return 4'b0001;
         DUR_QUARTER: return 4'b0010;
         DUR_HALF:    return 4'b0100;
         DUR_WHOLE:   return 4'b1000;
         default:     return 4'b0000;
      endcase
   endfunction

   duration_quantizer #(.E(E), .CW(CW)) u_quant (
      .run_len_i (run_len_q),
      .dur_o     (quant_dur)
   );

   // A run reaching a whole note is emitted in place and the count restarts.
   always_comb begin
      cur_tone_d = cur_tone_q;
      run_len_d  = run_len_q;
      emit_dur   = DUR_NONE;
      if (note_index_ready) begin
         if (note_index == cur_tone_q) begin
            if (run_len_q + 1'b1 == WHOLE_CNT) begin
               emit_dur  = DUR_WHOLE;
               run_len_d = '0;
            end else begin
               run_len_d = run_len_q + 1'b1;
            end
         end else begin
            emit_dur   = quant_dur;
            cur_tone_d = note_index;
            run_len_d  = CW'(1);
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cur_tone_q   <= '0;
         run_len_q    <= '0;
         ready_q      <= 1'b0;
         tone_q       <= '0;
         note_flags_q <= '0;
         rest_flags_q <= '0;
      end else begin
         cur_tone_q   <= cur_tone_d;
         run_len_q    <= run_len_d;
         ready_q      <= (emit_dur != DUR_NONE);
         note_flags_q <= '0;
         rest_flags_q <= '0;
         if (emit_dur != DUR_NONE) begin
            tone_q <= cur_tone_q;
            if (cur_tone_q == REST_INDEX) rest_flags_q <= dur_onehot(emit_dur);
            else                          note_flags_q <= dur_onehot(emit_dur);
         end
      end
   end

   assign new_note_ready = ready_q;
   assign new_note_tone  = tone_q;
   assign eighth_note    = note_flags_q[0];
   assign quarter_note   = note_flags_q[1];
   assign half_note      = note_flags_q[2];
   assign whole_note     = note_flags_q[3];
   assign eighth_rest    = rest_flags_q[0];
   assign quarter_rest   = rest_flags_q[1];
   assign half_rest      = rest_flags_q[2];
   assign whole_rest     = rest_flags_q[3];

endmodule

// File: tb/tb_duration_detector.sv
// Directed bench for duration_detector at default tempo (E = 1500 samples).
// Follows DURATION_DETECTOR_GLITCH_FILTER_EN for the short-rest expectation.
module tb_duration_detector;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic [5:0] note_index = '0;
   logic       note_index_ready = 1'b0;
   logic       new_note_ready;
   logic [5:0] new_note_tone;
   logic       eighth_note, quarter_note, half_note, whole_note;
   logic       eighth_rest, quarter_rest, half_rest, whole_rest;
   logic [7:0] flags;

   // flag vector order: {rests whole..eighth, notes whole..eighth}
   localparam logic [7:0] F_EIGHTH_N  = 8'b0000_0001;
   localparam logic [7:0] F_QUARTER_N = 8'b0000_0010;
   localparam logic [7:0] F_WHOLE_N   = 8'b0000_1000;
   localparam logic [7:0] F_EIGHTH_R  = 8'b0001_0000;
   localparam logic [7:0] F_HALF_R    = 8'b0100_0000;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int leak = 0;
   logic [5:0] obs_tone[$];
   logic [7:0] obs_flags[$];
   int         obs_cyc[$];

   duration_detector dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .note_index       (note_index),
      .note_index_ready (note_index_ready),
      .new_note_ready   (new_note_ready),
      .new_note_tone    (new_note_tone),
      .eighth_note      (eighth_note),
      .quarter_note     (quarter_note),
      .half_note        (half_note),
      .whole_note       (whole_note),
      .eighth_rest      (eighth_rest),
      .quarter_rest     (quarter_rest),
      .half_rest        (half_rest),
      .whole_rest       (whole_rest)
   );

   assign flags = {whole_rest, half_rest, quarter_rest, eighth_rest,
                   whole_note, half_note, quarter_note, eighth_note};

   // clock / cycle counter
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // event collector, sampled on the falling edge
   always @(negedge clk_in) begin
      if (new_note_ready) begin
         obs_tone.push_back(new_note_tone);
         obs_flags.push_back(flags);
         obs_cyc.push_back(cyc);
         if ($countones(flags) != 1) leak++;
      end else if (flags != 8'h00) begin
         leak++;
      end
   end

   task automatic clear_obs();
      obs_tone.delete();
      obs_flags.delete();
      obs_cyc.delete();
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      note_index_ready = 1'b0;
      note_index = '0;
      repeat (2) @(negedge clk_in);
      clear_obs();
      rst_in = 1'b0;
   endtask

   // drive n consecutive strobed samples; c0 = cycle stamp of the first one
   task automatic run(input logic [5:0] idx, input int n, output int c0);
      c0 = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         if (i == 0) c0 = cyc;
         note_index = idx;
         note_index_ready = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk_in);
      note_index_ready = 1'b0;
      repeat (n) @(negedge clk_in);
   endtask

   task automatic test_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      n_cmp++;
      if (new_note_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready: got %b want 0", new_note_ready);
      end
      n_cmp++;
      if (new_note_tone !== 6'd0) begin
         n_bad++; $display("FAIL reset_tone: got %0d want 0", new_note_tone);
      end
      n_cmp++;
      if (flags !== 8'h00) begin
         n_bad++; $display("FAIL reset_flags: got %b want 00000000", flags);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic test_whole_run();
      int c;
      do_reset();
      run(6'd10, 11960, c);
      run(6'd0, 1, c);
      idle(4);
      n_cmp++;
      if (obs_tone.size() !== 1) begin
         n_bad++; $display("FAIL whole_run_count: got %0d want 1", obs_tone.size());
      end
      if (obs_tone.size() > 0) begin
         n_cmp++;
         if (obs_tone[0] !== 6'd10) begin
            n_bad++; $display("FAIL whole_run_tone: got %0d want 10", obs_tone[0]);
         end
         n_cmp++;
         if (obs_flags[0] !== F_WHOLE_N) begin
            n_bad++; $display("FAIL whole_run_flags: got %b want %b", obs_flags[0], F_WHOLE_N);
         end
      end
   endtask

   task automatic test_glitch_rest();
      int c;
      int exp_n;
`ifdef DURATION_DETECTOR_GLITCH_FILTER_EN
      exp_n = 1;
`else
      exp_n = 2;
`endif
      do_reset();
      run(6'd10, 11960, c);
      run(6'd0, 100, c);
      run(6'd10, 1, c);
      idle(4);
      n_cmp++;
      if (obs_tone.size() !== exp_n) begin
         n_bad++; $display("FAIL glitch_count: got %0d want %0d", obs_tone.size(), exp_n);
      end
      if (obs_tone.size() > 0) begin
         n_cmp++;
         if (obs_tone[0] !== 6'd10 || obs_flags[0] !== F_WHOLE_N) begin
            n_bad++; $display("FAIL glitch_first: got tone %0d flags %b want tone 10 flags %b",
                              obs_tone[0], obs_flags[0], F_WHOLE_N);
         end
      end
      if (exp_n == 2 && obs_tone.size() > 1) begin
         n_cmp++;
         if (obs_tone[1] !== 6'd0 || obs_flags[1] !== F_EIGHTH_R) begin
            n_bad++; $display("FAIL glitch_rest: got tone %0d flags %b want tone 0 flags %b",
                              obs_tone[1], obs_flags[1], F_EIGHTH_R);
         end
      end
   endtask

   task automatic test_back_to_back();
      int c5, c7, c9;
      do_reset();
      run(6'd5, 1500, c5);
      run(6'd7, 3000, c7);
      run(6'd9, 1, c9);
      idle(4);
      n_cmp++;
      if (obs_tone.size() !== 2) begin
         n_bad++; $display("FAIL b2b_count: got %0d want 2", obs_tone.size());
      end
      if (obs_tone.size() > 1) begin
         n_cmp++;
         if (obs_tone[0] !== 6'd5) begin
            n_bad++; $display("FAIL b2b_tone0: got %0d want 5", obs_tone[0]);
         end
         n_cmp++;
         if (obs_flags[0] !== F_EIGHTH_N) begin
            n_bad++; $display("FAIL b2b_flags0: got %b want %b", obs_flags[0], F_EIGHTH_N);
         end
         n_cmp++;
         if (obs_cyc[0] !== c7 + 1) begin
            n_bad++; $display("FAIL b2b_cyc0: got %0d want %0d", obs_cyc[0], c7 + 1);
         end
         n_cmp++;
         if (obs_tone[1] !== 6'd7) begin
            n_bad++; $display("FAIL b2b_tone1: got %0d want 7", obs_tone[1]);
         end
         n_cmp++;
         if (obs_flags[1] !== F_QUARTER_N) begin
            n_bad++; $display("FAIL b2b_flags1: got %b want %b", obs_flags[1], F_QUARTER_N);
         end
         n_cmp++;
         if (obs_cyc[1] !== c9 + 1) begin
            n_bad++; $display("FAIL b2b_cyc1: got %0d want %0d", obs_cyc[1], c9 + 1);
         end
      end
   endtask

   task automatic test_half_rest();
      int c;
      do_reset();
      run(6'd0, 6000, c);
      run(6'd3, 1, c);
      idle(4);
      n_cmp++;
      if (obs_tone.size() !== 1) begin
         n_bad++; $display("FAIL half_rest_count: got %0d want 1", obs_tone.size());
      end
      if (obs_tone.size() > 0) begin
         n_cmp++;
         if (obs_tone[0] !== 6'd0) begin
            n_bad++; $display("FAIL half_rest_tone: got %0d want 0", obs_tone[0]);
         end
         n_cmp++;
         if (obs_flags[0] !== F_HALF_R) begin
            n_bad++; $display("FAIL half_rest_flags: got %b want %b", obs_flags[0], F_HALF_R);
         end
      end
   endtask

   task automatic test_held_whole();
      int c;
      do_reset();
      run(6'd4, 24001, c);
      idle(4);
      n_cmp++;
      if (obs_tone.size() !== 2) begin
         n_bad++; $display("FAIL held_count: got %0d want 2", obs_tone.size());
      end
      if (obs_tone.size() > 1) begin
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_tone[k] !== 6'd4 || obs_flags[k] !== F_WHOLE_N) begin
               n_bad++; $display("FAIL held_event%0d: got tone %0d flags %b want tone 4 flags %b",
                                 k, obs_tone[k], obs_flags[k], F_WHOLE_N);
            end
            n_cmp++;
            if (obs_cyc[k] !== c + 12000 * (k + 1)) begin
               n_bad++; $display("FAIL held_cyc%0d: got %0d want %0d",
                                 k, obs_cyc[k], c + 12000 * (k + 1));
            end
         end
      end
      n_cmp++;
      if (new_note_tone !== 6'd4) begin
         n_bad++; $display("FAIL held_tone_hold: got %0d want 4", new_note_tone);
      end
   endtask

   task automatic test_reset_mid_run();
      int c;
      do_reset();
      run(6'd6, 1500, c);
      run(6'd2, 800, c);
      n_cmp++;
      if (obs_tone.size() !== 1) begin
         n_bad++; $display("FAIL midrst_pre_count: got %0d want 1", obs_tone.size());
      end
      #2;
      rst_in = 1'b1;
      #1;
      n_cmp++;
      if (new_note_tone !== 6'd0) begin
         n_bad++; $display("FAIL midrst_tone: got %0d want 0", new_note_tone);
      end
      n_cmp++;
      if (new_note_ready !== 1'b0 || flags !== 8'h00) begin
         n_bad++; $display("FAIL midrst_outputs: got ready %b flags %b want 0", new_note_ready, flags);
      end
      @(negedge clk_in);
      note_index_ready = 1'b0;
      clear_obs();
      @(negedge clk_in);
      rst_in = 1'b0;
      run(6'd2, 1500, c);
      run(6'd0, 1, c);
      idle(4);
      n_cmp++;
      if (obs_tone.size() !== 1) begin
         n_bad++; $display("FAIL midrst_post_count: got %0d want 1", obs_tone.size());
      end
      if (obs_tone.size() > 0) begin
         n_cmp++;
         if (obs_tone[0] !== 6'd2 || obs_flags[0] !== F_EIGHTH_N) begin
            n_bad++; $display("FAIL midrst_post_event: got tone %0d flags %b want tone 2 flags %b",
                              obs_tone[0], obs_flags[0], F_EIGHTH_N);
         end
      end
   endtask

   task automatic test_flag_hygiene();
      n_cmp++;
      if (leak !== 0) begin
         n_bad++; $display("FAIL flag_hygiene: got %0d bad flag cycles want 0", leak);
      end
   endtask

   initial begin
      test_reset();
      test_whole_run();
      test_glitch_rest();
      test_back_to_back();
      test_half_rest();
      test_held_whole();
      test_reset_mid_run();
      test_flag_hygiene();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
